// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: controller FSM states, NOP encoding, drain default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

   // Controller operating modes
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } state_e;

   // addi x0,x0,0 -- what the stage registers load when flushed
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Bubble cycles needed to empty IF..WB once fetch has stopped
   localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running event counter with increment enable, wraps modulo 2^CNT_W.
// Latency: count visible one cycle after the enabled edge.
// Backpressure: none; counts every enabled cycle.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: natural binary wrap on overflow
   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: stage enables, bubbles, PC redirect, halt drain.
// Latency: enables/flushes/pc_sel are combinational (same edge); state and counters registered.
// Backpressure: a data-memory wait freezes every stage until mem_ready.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             suspend,
   input  logic             ex_redirect,
   input  logic [31:0]      ex_target,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pc_sel,
   output logic [31:0]      redirect_pc,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_e        state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;

   logic mem_wait;
   logic do_step;
   logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
   logic if_id_flush_c, id_ex_flush_c, pc_sel_c, halted_c;
   logic stall_inc, flush_inc;

   assign mem_wait = mem_req && !mem_ready;

   // Next state, drain count and stage controls from current mode and hazards
   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      do_step       = 1'b0;
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      id_ex_en_c    = 1'b0;
      ex_mem_en_c   = 1'b0;
      mem_wb_en_c   = 1'b0;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      pc_sel_c      = 1'b0;
      halted_c      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_wait) begin
               state_d = ST_MEM_WAIT;
            end else begin
               do_step = 1'b1;
               if (halt_req) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
         end
         ST_MEM_WAIT: begin
            // EX is frozen while waiting, so a pending redirect is still presented on release
            if (mem_ready) begin
               do_step = 1'b1;
               if (halt_req) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LOAD;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_DRAIN: begin
            // Fetch stopped; bubbles enter IF/ID while the older instructions retire
            if (!mem_wait) begin
               if_id_en_c    = 1'b1;
               id_ex_en_c    = 1'b1;
               ex_mem_en_c   = 1'b1;
               mem_wb_en_c   = 1'b1;
               if_id_flush_c = 1'b1;
               if (drain_q == '0) begin
                  state_d = ST_HALTED;
               end else begin
                  drain_d = drain_q - DW'(1);
               end
            end
         end
         ST_HALTED: begin
            halted_c = 1'b1;
            if (resume) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Normal pipeline step: redirect squashes the wrong-path ID instruction, so it beats load-use
      if (do_step) begin
         if (ex_redirect) begin
            pc_sel_c      = 1'b1;
            pc_en_c       = 1'b1;
            if_id_en_c    = 1'b1;
            id_ex_en_c    = 1'b1;
            ex_mem_en_c   = 1'b1;
            mem_wb_en_c   = 1'b1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
         end else if (suspend) begin
            id_ex_en_c    = 1'b1;
            ex_mem_en_c   = 1'b1;
            mem_wb_en_c   = 1'b1;
            id_ex_flush_c = 1'b1;
         end else begin
            pc_en_c       = 1'b1;
            if_id_en_c    = 1'b1;
            id_ex_en_c    = 1'b1;
            ex_mem_en_c   = 1'b1;
            mem_wb_en_c   = 1'b1;
         end
      end

      stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en_c;
      flush_inc = do_step && ex_redirect;
   end

   // Mode and drain-count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Everything held quiet while in reset
   assign pc_en       = rst_n & pc_en_c;
   assign if_id_en    = rst_n & if_id_en_c;
   assign id_ex_en    = rst_n & id_ex_en_c;
   assign ex_mem_en   = rst_n & ex_mem_en_c;
   assign mem_wb_en   = rst_n & mem_wb_en_c;
   assign if_id_flush = rst_n & if_id_flush_c;
   assign id_ex_flush = rst_n & id_ex_flush_c;
   assign pc_sel      = rst_n & pc_sel_c;
   assign halted      = rst_n & halted_c;
   assign redirect_pc = ex_target;

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .cnt   (stall_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        suspend = 1'b0, ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic        halt_req = 1'b0, resume = 1'b0;
   logic [31:0] ex_target = 32'h0;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, pc_sel, halted;
   logic [31:0] redirect_pc, stall_cnt, flush_cnt;

   // 8-bit counter build, used only for the wrap check
   logic        r8_redirect = 1'b0;
   logic        r8_pc_en, r8_if_id_en, r8_id_ex_en, r8_ex_mem_en, r8_mem_wb_en;
   logic        r8_if_id_flush, r8_id_ex_flush, r8_pc_sel, r8_halted;
   logic [31:0] r8_redirect_pc;
   logic [7:0]  r8_stall_cnt, r8_flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .suspend(suspend), .ex_redirect(ex_redirect),
      .ex_target(ex_target), .mem_req(mem_req), .mem_ready(mem_ready),
      .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_sel(pc_sel),
      .redirect_pc(redirect_pc), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .suspend(1'b0), .ex_redirect(r8_redirect),
      .ex_target(32'h0), .mem_req(1'b0), .mem_ready(1'b0),
      .halt_req(1'b0), .resume(1'b0), .pc_en(r8_pc_en), .if_id_en(r8_if_id_en),
      .id_ex_en(r8_id_ex_en), .ex_mem_en(r8_ex_mem_en), .mem_wb_en(r8_mem_wb_en),
      .if_id_flush(r8_if_id_flush), .id_ex_flush(r8_id_ex_flush), .pc_sel(r8_pc_sel),
      .redirect_pc(r8_redirect_pc), .halted(r8_halted), .stall_cnt(r8_stall_cnt),
      .flush_cnt(r8_flush_cnt)
   );

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, pc_sel, halted}
   wire [8:0] ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, pc_sel, halted};

   localparam logic [8:0] O_NORM  = 9'b111110000;
   localparam logic [8:0] O_LOAD  = 9'b001110100;
   localparam logic [8:0] O_REDIR = 9'b111111110;
   localparam logic [8:0] O_FROZE = 9'b000000000;
   localparam logic [8:0] O_DRAIN = 9'b011111000;
   localparam logic [8:0] O_HALT  = 9'b000000001;

   // ---------------- reference model ----------------
   localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;
   int          m_mode = M_RUN;
   int          m_left = 0;       // drain cycles still to perform
   logic [31:0] m_stall = 0, m_flush = 0;

   task automatic model_reset();
      m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0;
   endtask

   // Expected controls for the current mode and inputs, plus counter events
   task automatic model_outputs(output logic [8:0] o, output bit stalled, output bit redirected);
      bit frozen;
      o = O_FROZE; stalled = 0; redirected = 0;
      if (rst_n) begin
         if (m_mode == M_RUN || m_mode == M_WAIT) begin
            frozen = (m_mode == M_RUN) ? (mem_req && !mem_ready) : !mem_ready;
            if (!frozen) begin
               if (ex_redirect) begin o = O_REDIR; redirected = 1; end
               else if (suspend) o = O_LOAD;
               else o = O_NORM;
            end
            stalled = (o[8] == 1'b0);
         end else if (m_mode == M_DRAIN) begin
            if (!(mem_req && !mem_ready)) o = O_DRAIN;
         end else begin
            o = O_HALT;
         end
      end
   endtask

   // Advance the model across one clock edge
   task automatic model_advance(input bit stalled, input bit redirected);
      if (!rst_n) begin
         model_reset();
      end else begin
         m_stall = m_stall + 32'(stalled);
         m_flush = m_flush + 32'(redirected);
         case (m_mode)
            M_RUN: begin
               if (mem_req && !mem_ready) m_mode = M_WAIT;
               else if (halt_req) begin m_mode = M_DRAIN; m_left = 4; end
            end
            M_WAIT: begin
               if (mem_ready) begin
                  if (halt_req) begin m_mode = M_DRAIN; m_left = 4; end
                  else m_mode = M_RUN;
               end
            end
            M_DRAIN: begin
               if (!(mem_req && !mem_ready)) begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_mode = M_HALT;
               end
            end
            default: if (resume) m_mode = M_RUN;
         endcase
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: compare controls and counters at the falling edge, then cross the rising edge.
   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic step(input string tag, output logic [8:0] seen);
      logic [8:0] o; bit st, rd;
      @(negedge clk);
      model_outputs(o, st, rd);
      seen = ctl;
      chk({tag, ".ctl"}, 32'(ctl), 32'(o));
      chk({tag, ".rpc"}, redirect_pc, ex_target);
      chk({tag, ".stall"}, stall_cnt, m_stall);
      chk({tag, ".flush"}, flush_cnt, m_flush);
      @(posedge clk);
      model_advance(st, rd);
      #1;
   endtask

   task automatic idle_inputs();
      suspend = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0; halt_req = 0; resume = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst_n = 0;
      model_reset();
      @(negedge clk);
      chk("rst.ctl", 32'(ctl), 32'(O_FROZE));
      chk("rst.stall", stall_cnt, 32'h0);
      chk("rst.flush", flush_cnt, 32'h0);
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       sus, red, mreq, mrdy, hreq, res;
      logic [8:0] exp;
   } vec_t;

   vec_t vt[8];

   initial begin
      logic [8:0] seen;

      // sus red mreq mrdy hreq res : expected controls (applied in order from RUN)
      vt[0] = '{0, 0, 0, 0, 0, 0, O_NORM};   // plain step
      vt[1] = '{1, 0, 0, 0, 0, 0, O_LOAD};   // load-use bubble
      vt[2] = '{1, 1, 0, 0, 0, 0, O_REDIR};  // redirect beats suspend
      vt[3] = '{0, 0, 1, 1, 0, 0, O_NORM};   // memory answers at once
      vt[4] = '{0, 1, 1, 0, 0, 0, O_FROZE};  // memory wait beats redirect
      vt[5] = '{0, 1, 1, 0, 0, 0, O_FROZE};  // still waiting
      vt[6] = '{0, 1, 1, 1, 0, 0, O_REDIR};  // release applies the held redirect
      vt[7] = '{0, 0, 0, 0, 0, 1, O_NORM};   // resume outside HALTED ignored

      do_reset();
      ex_target = 32'h0000_2000;
      for (int i = 0; i < 8; i++) begin
         suspend = vt[i].sus; ex_redirect = vt[i].red; mem_req = vt[i].mreq;
         mem_ready = vt[i].mrdy; halt_req = vt[i].hreq; resume = vt[i].res;
         step($sformatf("vec%0d", i), seen);
         chk($sformatf("vec%0d.tbl", i), 32'(seen), 32'(vt[i].exp));
      end
      idle_inputs();
      step("vec_end", seen);
      chk("vec.stall_total", stall_cnt, 32'd3);
      chk("vec.flush_total", flush_cnt, 32'd2);

      // Load-use: exactly one bubble
      do_reset();
      suspend = 1;
      step("lu.bubble", seen);
      chk("lu.bubble.tbl", 32'(seen), 32'(O_LOAD));
      suspend = 0;
      step("lu.after", seen);
      chk("lu.after.tbl", 32'(seen), 32'(O_NORM));
      chk("lu.stall_cnt", stall_cnt, 32'd1);

      // Redirect with simultaneous suspend
      do_reset();
      ex_target = 32'h0000_0100; ex_redirect = 1; suspend = 1;
      step("br.cycle", seen);
      chk("br.cycle.tbl", 32'(seen), 32'(O_REDIR));
      chk("br.redirect_pc", redirect_pc, 32'h0000_0100);
      idle_inputs();
      step("br.after", seen);
      chk("br.after.tbl", 32'(seen), 32'(O_NORM));
      chk("br.flush_cnt", flush_cnt, 32'd1);
      chk("br.stall_cnt", stall_cnt, 32'd0);

      // Memory wait: entry cycle in RUN plus three waiting cycles, then release
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         step($sformatf("mw.wait%0d", i), seen);
         chk($sformatf("mw.wait%0d.tbl", i), 32'(seen), 32'(O_FROZE));
      end
      mem_ready = 1;
      step("mw.release", seen);
      chk("mw.release.tbl", 32'(seen), 32'(O_NORM));
      idle_inputs();
      step("mw.after", seen);
      chk("mw.stall_cnt", stall_cnt, 32'd4);

      // Halt drain, then resume while halt_req is still high
      do_reset();
      halt_req = 1;
      step("h.entry", seen);
      chk("h.entry.tbl", 32'(seen), 32'(O_NORM));
      for (int i = 0; i < 4; i++) begin
         step($sformatf("h.drain%0d", i), seen);
         chk($sformatf("h.drain%0d.tbl", i), 32'(seen), 32'(O_DRAIN));
      end
      step("h.halted", seen);
      chk("h.halted.tbl", 32'(seen), 32'(O_HALT));
      resume = 1;
      step("h.resume", seen);
      chk("h.resume.tbl", 32'(seen), 32'(O_HALT));
      resume = 0; halt_req = 0;
      step("h.run", seen);
      chk("h.run.tbl", 32'(seen), 32'(O_NORM));

      // Reset in the middle of a drain
      do_reset();
      ex_redirect = 1; suspend = 1;
      step("rd.br", seen);
      idle_inputs();
      halt_req = 1;
      step("rd.entry", seen);
      halt_req = 0;
      step("rd.drain0", seen);
      chk("rd.drain0.tbl", 32'(seen), 32'(O_DRAIN));
      chk("rd.flush_pre", flush_cnt, 32'd1);
      rst_n = 0;
      model_reset();
      #1;
      chk("rd.in_reset.ctl", 32'(ctl), 32'(O_FROZE));
      chk("rd.in_reset.stall", stall_cnt, 32'd0);
      chk("rd.in_reset.flush", flush_cnt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      step("rd.first", seen);
      chk("rd.first.tbl", 32'(seen), 32'(O_NORM));

      // 8-bit flush counter wraps
      @(posedge clk); #1;
      r8_redirect = 1;
      repeat (255) @(posedge clk);
      #1;
      chk("w8.flush_255", 32'(r8_flush_cnt), 32'd255);
      @(posedge clk); #1;
      chk("w8.flush_wrap", 32'(r8_flush_cnt), 32'd0);
      chk("w8.stall", 32'(r8_stall_cnt), 32'd0);
      r8_redirect = 0;

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         suspend     = ($urandom_range(0, 3) == 0);
         ex_redirect = ($urandom_range(0, 4) == 0);
         mem_req     = ($urandom_range(0, 2) == 0);
         mem_ready   = ($urandom_range(0, 1) == 0);
         halt_req    = ($urandom_range(0, 11) == 0);
         resume      = ($urandom_range(0, 3) == 0);
         ex_target   = $urandom;
         step("rnd", seen);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
